// File: rtl/aes_io_sequencer.sv
// rtl/aes_io_sequencer.sv - byte-serial host sequencer for the AES round controller
// Optional BUSY watchdog with err pulse: define AES_IO_TIMEOUT_EN.
module aes_io_sequencer #(
   parameter int NBYTES  = 16,
   parameter int BW      = 8,
   parameter int TIMEOUT = 63
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   input  logic          cmd_dec,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [BW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [BW-1:0] out_data,
   output logic          load_shift,
   output logic [BW-1:0] shift_out,
   input  logic [BW-1:0] shift_in,
   output logic          staenc,
   output logic          stadec,
   input  logic          core_done,
   output logic          busy,
   output logic          err
);
   localparam int CW = $clog2(NBYTES);
   localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

   typedef enum logic [2:0] {IDLE, LOAD, START, BUSY, UNLOAD} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          mode, mode_nxt;

`ifdef AES_IO_TIMEOUT_EN
   logic [5:0] tcnt, tcnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) tcnt <= '0;
      else     tcnt <= tcnt_nxt;
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         mode  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         mode  <= mode_nxt;
      end
   end

   // Result bytes are presented straight from the datapath serial output.
   assign out_data = shift_in;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      mode_nxt   = mode;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      load_shift = 1'b0;
      shift_out  = '0;
      staenc     = 1'b0;
      stadec     = 1'b0;
      err        = 1'b0;
`ifdef AES_IO_TIMEOUT_EN
      tcnt_nxt   = tcnt;
`endif
      unique case (state)
         IDLE: begin
            if (cmd_valid) begin
               mode_nxt  = cmd_dec;
               cnt_nxt   = '0;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            in_ready  = 1'b1;
            shift_out = in_data;
            if (in_valid) begin
               load_shift = 1'b1;
               if (cnt == LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = START;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         START: begin
            staenc = ~mode;
            stadec = mode;
`ifdef AES_IO_TIMEOUT_EN
            tcnt_nxt = '0;
`endif
            // A fast core may finish in the same cycle it is started.
            state_nxt = core_done ? UNLOAD : BUSY;
         end
         BUSY: begin
            if (core_done) begin
               state_nxt = UNLOAD;
`ifdef AES_IO_TIMEOUT_EN
            end else if (tcnt == 6'(TIMEOUT - 1)) begin
               err       = 1'b1;
               state_nxt = IDLE;
            end else begin
               tcnt_nxt = tcnt + 6'd1;
`endif
            end
         end
         UNLOAD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               load_shift = 1'b1;
               if (cnt == LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Reset wins over any handshake or start in the same cycle.
      if (rst) begin
         in_ready   = 1'b0;
         out_valid  = 1'b0;
         load_shift = 1'b0;
         shift_out  = '0;
         staenc     = 1'b0;
         stadec     = 1'b0;
         err        = 1'b0;
      end
   end

   assign busy = (state != IDLE) && !rst;

endmodule

// File: tb/tb_aes_io_sequencer.sv
// tb/tb_aes_io_sequencer.sv - directed self-checking bench for aes_io_sequencer
module tb_aes_io_sequencer;
   logic       clk = 1'b0;
   logic       rst, cmd_valid, cmd_dec, in_valid, in_ready, out_valid, out_ready;
   logic       load_shift, staenc, stadec, core_done, busy, err;
   logic [7:0] in_data, out_data, shift_out, shift_in;
   int checks = 0, errors = 0;
   int enc_pulses = 0, dec_pulses = 0;

   always #5 clk = ~clk;

   aes_io_sequencer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_dec(cmd_dec),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .load_shift(load_shift), .shift_out(shift_out), .shift_in(shift_in),
      .staenc(staenc), .stadec(stadec), .core_done(core_done),
      .busy(busy), .err(err)
   );

   always @(negedge clk) begin
      if (staenc) enc_pulses++;
      if (stadec) dec_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Issue a command and feed 16 back-to-back bytes; returns in START.
   task automatic load16(input logic dec, input logic [7:0] base);
      cmd_valid = 1'b1; cmd_dec = dec;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_data = base + 8'(i);
         #1;
         check("load_shift_b2b", load_shift, 1);
         check("shift_out_b2b", shift_out, base + 8'(i));
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic unload16(input logic [7:0] base);
      out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         shift_in = base + 8'(k);
         #1;
         check("unload_valid", out_valid, 1);
         check("unload_data", out_data, base + 8'(k));
         tick();
      end
      out_ready = 1'b0;
      #1;
      check("unload_done_busy", busy, 0);
      check("unload_done_valid", out_valid, 0);
   endtask

   initial begin
      int k, n, cyc;
      rst = 1'b1; cmd_valid = 1'b0; cmd_dec = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      out_ready = 1'b0; shift_in = 8'h5A; core_done = 1'b0;
      repeat (3) tick();
      #1;
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_load_shift", load_shift, 0);
      check("rst_staenc", staenc, 0);
      check("rst_stadec", stadec, 0);
      check("rst_err", err, 0);
      check("rst_shift_out", shift_out, 8'h00);
      check("rst_out_data", out_data, 8'h5A);
      rst = 1'b0;

      // stray core_done in IDLE
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      #1;
      check("idle_core_done_busy", busy, 0);

      // encrypt, 0x00..0x0F back to back
      enc_pulses = 0; dec_pulses = 0;
      load16(1'b0, 8'h00);
      in_valid = 1'b1; in_data = 8'hFF;
      #1;
      check("start_in_ready", in_ready, 0);
      check("start_load_shift", load_shift, 0);
      check("start_staenc", staenc, 1);
      check("start_stadec", stadec, 0);
      tick();
      in_valid = 1'b0;
      cmd_valid = 1'b1; cmd_dec = 1'b1;
      #1;
      check("busy_staenc", staenc, 0);
      check("busy_busy", busy, 1);
      check("busy_out_valid", out_valid, 0);
      check("busy_load_shift", load_shift, 0);
      check("busy_in_ready", in_ready, 0);
      repeat (3) tick();
      cmd_valid = 1'b0;
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      // unload with out_ready 1,0,1 pattern
      k = 0; cyc = 0;
      while (k < 16 && cyc < 100) begin
         shift_in = 8'hA0 + 8'(k);
         out_ready = (cyc % 3) != 1;
         #1;
         check("toggle_valid", out_valid, 1);
         check("toggle_data", out_data, 8'hA0 + 8'(k));
         check("toggle_load_shift", load_shift, out_ready);
         tick();
         if (out_ready) k++;
         cyc++;
      end
      out_ready = 1'b0;
      #1;
      check("toggle_bytes", k, 16);
      check("toggle_end_busy", busy, 0);
      check("enc_pulse_count", enc_pulses, 1);
      check("enc_dec_count", dec_pulses, 0);

      // decrypt with gaps, stray core_done inside LOAD
      enc_pulses = 0; dec_pulses = 0;
      cmd_valid = 1'b1; cmd_dec = 1'b1;
      tick();
      cmd_valid = 1'b0;
      n = 0; cyc = 0;
      while (n < 16 && cyc < 100) begin
         in_valid = (cyc % 2) == 0;
         in_data = 8'h30 + 8'(n);
         core_done = (cyc == 5);
         #1;
         check("gap_in_ready", in_ready, 1);
         check("gap_load_shift", load_shift, in_valid);
         if (in_valid) check("gap_shift_out", shift_out, 8'h30 + 8'(n));
         tick();
         if (in_valid) n++;
         cyc++;
      end
      core_done = 1'b1;
      in_valid = 1'b1;
      #1;
      check("gap_bytes", n, 16);
      check("extra_in_ready", in_ready, 0);
      check("dec_stadec", stadec, 1);
      check("dec_staenc", staenc, 0);
      tick();
      core_done = 1'b0;
      in_valid = 1'b0;
      unload16(8'hC0);
      check("dec_pulse_count", dec_pulses, 1);
      check("dec_enc_count", enc_pulses, 0);

      // reset after byte 7 in LOAD
      enc_pulses = 0; dec_pulses = 0;
      cmd_valid = 1'b1; cmd_dec = 1'b0;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; in_data = 8'(i);
         tick();
      end
      rst = 1'b1;
      #1;
      check("rst_beats_handshake", load_shift, 0);
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_no_start", enc_pulses + dec_pulses, 0);
      load16(1'b0, 8'h50);
      #1;
      check("reload_staenc", staenc, 1);
      tick();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      unload16(8'h70);
      check("reload_enc_count", enc_pulses, 1);

`ifdef AES_IO_TIMEOUT_EN
      // watchdog: 63 BUSY cycles without core_done
      load16(1'b0, 8'h10);
      tick();
      for (int c = 1; c <= 63; c++) begin
         #1;
         check("to_err", err, (c == 63) ? 1 : 0);
         check("to_out_valid", out_valid, 0);
         tick();
      end
      #1;
      check("to_idle_busy", busy, 0);
      check("to_err_cleared", err, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
